mm_job_sched: RTL and testbench



---
 rtl/mm_job_sched_pkg.sv | 34 +++
 rtl/mm_job_sched_job_fifo.sv | 48 ++++
 rtl/mm_job_sched.sv | 145 ++++++++++++++
 tb/tb_mm_job_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_job_sched_pkg.sv
// Shared encodings for the matmul job scheduler: mode codes common with the MM
// controller and MAC, completion status codes, FSM states and descriptor sizing.
package mm_job_sched_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    MODE_INT8     = 2'd0,
    MODE_INT4     = 2'd1,
    MODE_INT4_VSQ = 2'd2
  } mm_mode_e;

  typedef enum logic [1:0] {
    CMP_OK            = 2'd0,
    CMP_TILE_MISMATCH = 2'd1,
    CMP_TIMEOUT       = 2'd2,
    CMP_RSVD          = 2'd3
  } cmp_status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_RUN    = 3'd2,
    S_REPORT = 3'd3,
    S_DRAIN  = 3'd4,
    S_HALT   = 3'd5
  } sched_state_e;

  // Descriptor layout is {mode, tiles, tag}, MSB first.
  function automatic int desc_width(input int tile_w, input int tag_w);
    return MODE_W + tile_w + tag_w;
  endfunction

endpackage

// File: rtl/mm_job_sched_job_fifo.sv
// Synchronous job-descriptor FIFO with first-word-fall-through head and a
// synchronous flush that empties it in one cycle.
module mm_job_sched_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: storage is left unreset; the pointers alone decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) mem[wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) wr_ptr <= wr_ptr + PTR_ONE;
      if (i_pop && !o_empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mm_job_sched.sv
// Job scheduler in front of the MM controller: queues descriptors, issues one
// job at a time, counts tiles, detects stalls and returns a completion record.
module mm_job_sched
  import mm_job_sched_pkg::*;
#(
  parameter int QD     = 4,
  parameter int TAG_W  = 4,
  parameter int TILE_W = 16,
  parameter int TO_W   = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_job_valid,
  output logic              o_job_ready,
  input  logic [1:0]        i_job_mode,
  input  logic [TILE_W-1:0] i_job_tiles,
  input  logic [TAG_W-1:0]  i_job_tag,
  output logic              o_mm_start,
  output logic [1:0]        o_mm_mode,
  input  logic              i_mm_tile_done,
  input  logic              i_mm_mtrx_done,
  input  logic [TO_W-1:0]   i_timeout,
  input  logic              i_abort,
  output logic              o_cmp_valid,
  input  logic              i_cmp_ready,
  output logic [TAG_W-1:0]  o_cmp_tag,
  output logic [1:0]        o_cmp_status,
  output logic              o_busy
);

  localparam int DW = desc_width(TILE_W, TAG_W);
  localparam logic [TILE_W-1:0] TILE_ONE = 1;
  localparam logic [TO_W-1:0]   TO_ONE   = 1;

  sched_state_e      state_q, state_d;
  logic [1:0]        cur_mode_q;
  logic [TILE_W-1:0] cur_tiles_q;
  logic [TAG_W-1:0]  cur_tag_q;
  logic [TILE_W-1:0] tile_cnt_q;
  logic [TO_W-1:0]   stall_cnt_q;
  cmp_status_e       status_q;
  logic              start_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DW-1:0]     fifo_head;
  logic [1:0]        head_mode;
  logic [TILE_W-1:0] head_tiles;
  logic [TAG_W-1:0]  head_tag;
  logic [TILE_W-1:0] tile_cnt_inc, final_cnt;
  logic              timeout_hit;

  // A full queue refuses a push even when a pop frees a slot the same cycle.
  assign fifo_push = i_job_valid && !fifo_full;
  assign {head_mode, head_tiles, head_tag} = fifo_head;

  mm_job_sched_job_fifo #(
    .DEPTH (QD),
    .WIDTH (DW)
  ) u_job_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_abort),
    .i_push  (fifo_push),
    .i_din   ({i_job_mode, i_job_tiles, i_job_tag}),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign tile_cnt_inc = (tile_cnt_q == '1) ? tile_cnt_q : tile_cnt_q + TILE_ONE;
  assign final_cnt    = i_mm_tile_done ? tile_cnt_inc : tile_cnt_q;
  assign timeout_hit  = (i_timeout != '0) && (stall_cnt_q == i_timeout - TO_ONE)
                        && !i_mm_tile_done && !i_mm_mtrx_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = (state_q == S_RUN) ? S_DRAIN : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (!fifo_empty) state_d = S_ISSUE;
        S_ISSUE:  state_d = S_RUN;
        S_RUN:    if (i_mm_mtrx_done || timeout_hit) state_d = S_REPORT;
        S_REPORT: if (i_cmp_ready) state_d = (status_q == CMP_TIMEOUT) ? S_HALT : S_IDLE;
        S_DRAIN:  if (i_mm_mtrx_done) state_d = S_IDLE;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_pop     = (state_q == S_IDLE) && !fifo_empty && !i_abort;
    o_cmp_valid  = (state_q == S_REPORT) && !i_abort;
    o_busy       = (state_q != S_IDLE) || !fifo_empty;
    o_job_ready  = !fifo_full;
    o_mm_start   = start_q;
    o_mm_mode    = cur_mode_q;
    o_cmp_tag    = cur_tag_q;
    o_cmp_status = status_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_q     <= 1'b0;
      cur_mode_q  <= '0;
      cur_tiles_q <= '0;
      cur_tag_q   <= '0;
      tile_cnt_q  <= '0;
      stall_cnt_q <= '0;
      status_q    <= CMP_OK;
    end else begin
      start_q <= (state_d == S_ISSUE);
      if (fifo_pop) begin
        cur_mode_q  <= head_mode;
        cur_tiles_q <= head_tiles;
        cur_tag_q   <= head_tag;
      end
      case (state_q)
        S_ISSUE: begin
          tile_cnt_q  <= '0;
          stall_cnt_q <= '0;
        end
        S_RUN: begin
          tile_cnt_q  <= final_cnt;
          stall_cnt_q <= i_mm_tile_done ? '0 : stall_cnt_q + TO_ONE;
          // A tile_done coinciding with mtrx_done is already folded into final_cnt.
          if (i_mm_mtrx_done)
            status_q <= (final_cnt == cur_tiles_q) ? CMP_OK : CMP_TILE_MISMATCH;
          else if (timeout_hit)
            status_q <= CMP_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_sched.sv
// Directed bench for mm_job_sched with a scoreboard of expected starts and
// completions checked by a negedge monitor.
module tb_mm_job_sched;
  import mm_job_sched_pkg::*;

  localparam int QD = 4, TAG_W = 4, TILE_W = 16, TO_W = 20;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_job_valid = 1'b0;
  logic              o_job_ready;
  logic [1:0]        i_job_mode = '0;
  logic [TILE_W-1:0] i_job_tiles = '0;
  logic [TAG_W-1:0]  i_job_tag = '0;
  logic              o_mm_start;
  logic [1:0]        o_mm_mode;
  logic              i_mm_tile_done = 1'b0;
  logic              i_mm_mtrx_done = 1'b0;
  logic [TO_W-1:0]   i_timeout = '0;
  logic              i_abort = 1'b0;
  logic              o_cmp_valid;
  logic              i_cmp_ready = 1'b1;
  logic [TAG_W-1:0]  o_cmp_tag;
  logic [1:0]        o_cmp_status;
  logic              o_busy;

  mm_job_sched #(.QD(QD), .TAG_W(TAG_W), .TILE_W(TILE_W), .TO_W(TO_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_mode(i_job_mode), .i_job_tiles(i_job_tiles), .i_job_tag(i_job_tag),
    .o_mm_start(o_mm_start), .o_mm_mode(o_mm_mode),
    .i_mm_tile_done(i_mm_tile_done), .i_mm_mtrx_done(i_mm_mtrx_done),
    .i_timeout(i_timeout), .i_abort(i_abort),
    .o_cmp_valid(o_cmp_valid), .i_cmp_ready(i_cmp_ready),
    .o_cmp_tag(o_cmp_tag), .o_cmp_status(o_cmp_status), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [1:0]       status;
  } cmp_t;

  cmp_t       exp_cmp[$];
  logic [1:0] exp_start[$];
  logic [1:0] exp_mode = '0;
  bit         mode_valid = 1'b0;
  int         last_hs_cyc = -100;
  bit         auto_mm = 1'b0;
  cmp_t       mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_job(input logic [1:0] mode, input logic [TAG_W-1:0] tag,
                            input logic [1:0] status, input bit completes);
    cmp_t e;
    exp_start.push_back(mode);
    if (completes) begin
      e.tag = tag;
      e.status = status;
      exp_cmp.push_back(e);
    end
  endtask

  task automatic push_job(input logic [1:0] mode, input logic [TILE_W-1:0] tiles,
                          input logic [TAG_W-1:0] tag);
    int guard = 0;
    i_job_valid = 1'b1;
    i_job_mode  = mode;
    i_job_tiles = tiles;
    i_job_tag   = tag;
    while (!o_job_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!o_job_ready) check("push_ready_timeout", 0, 1);
    tick();
    i_job_valid = 1'b0;
  endtask

  task automatic wait_start(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (o_mm_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("start_seen", ok, 1);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && o_busy; i++) tick();
    check("idle_reached", o_busy, 0);
  endtask

  task automatic drive_tiles(input int n, input bit mtrx_with_last);
    for (int i = 0; i < n; i++) begin
      i_mm_tile_done = 1'b1;
      i_mm_mtrx_done = mtrx_with_last && (i == n - 1);
      tick();
    end
    i_mm_tile_done = 1'b0;
    i_mm_mtrx_done = 1'b0;
    if (!mtrx_with_last) begin
      i_mm_mtrx_done = 1'b1;
      tick();
      i_mm_mtrx_done = 1'b0;
    end
  endtask

  // Monitor: starts and completion handshakes are popped from the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_mm_start) begin
        if (exp_start.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          exp_mode   = exp_start.pop_front();
          mode_valid = 1'b1;
          check("start_gap_after_report", (cyc >= last_hs_cyc + 2), 1);
        end
      end
      if (mode_valid) check("mm_mode_held", o_mm_mode, exp_mode);
      if (o_cmp_valid && i_cmp_ready && !i_abort) begin
        last_hs_cyc = cyc;
        if (exp_cmp.size() == 0) begin
          check("unexpected_cmp", 1, 0);
        end else begin
          mon_e = exp_cmp.pop_front();
          check("cmp_tag", o_cmp_tag, mon_e.tag);
          check("cmp_status", o_cmp_status, mon_e.status);
        end
      end
    end
  end

  // Stand-in MM controller: one tile that also finishes the matrix.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (auto_mm && o_mm_start) begin
        tick();
        i_mm_tile_done = 1'b1;
        i_mm_mtrx_done = 1'b1;
        tick();
        i_mm_tile_done = 1'b0;
        i_mm_mtrx_done = 1'b0;
      end
    end
  end

  initial begin
    int k;
    int errs;
    logic [TAG_W-1:0] tag0;
    logic [1:0] st0;

    #1 i_rst = 1'b1;
    tick();
    tick();
    check("rst_start", o_mm_start, 0);
    check("rst_mode", o_mm_mode, 0);
    check("rst_cmp_valid", o_cmp_valid, 0);
    check("rst_cmp_tag", o_cmp_tag, 0);
    check("rst_cmp_status", o_cmp_status, 0);
    check("rst_busy", o_busy, 0);
    check("rst_job_ready", o_job_ready, 1);
    i_rst = 1'b0;
    tick();

    // Single job, 4 tiles, mtrx_done with the last tile; start in the cycle ending at edge T+2.
    expect_job(MODE_INT8, 4'd3, CMP_OK, 1'b1);
    push_job(MODE_INT8, 16'd4, 4'd3);
    check("start_not_early", o_mm_start, 0);
    tick();
    check("start_latency", o_mm_start, 1);
    tick();
    check("start_one_cycle", o_mm_start, 0);
    drive_tiles(4, 1'b1);
    wait_idle(20);

    // Five back-to-back jobs against a depth-4 queue.
    auto_mm = 1'b1;
    for (int j = 0; j < 5; j++) expect_job(2'(j % 3), 4'(j), CMP_OK, 1'b1);
    for (int j = 0; j < 5; j++) push_job(2'(j % 3), 16'd1, 4'(j));
    check("queue_full_ready_low", o_job_ready, 0);
    for (int i = 0; i < 300 && exp_cmp.size() != 0; i++) tick();
    check("burst_all_completed", exp_cmp.size(), 0);
    auto_mm = 1'b0;
    wait_idle(20);

    // Tile count short by one.
    expect_job(MODE_INT4, 4'd11, CMP_TILE_MISMATCH, 1'b1);
    push_job(MODE_INT4, 16'd4, 4'd11);
    wait_start(10);
    tick();
    drive_tiles(3, 1'b0);
    wait_idle(20);

    // Stall timeout, then HALT with a job still queued until abort.
    i_timeout = 20'd10;
    expect_job(MODE_INT4_VSQ, 4'd5, CMP_TIMEOUT, 1'b1);
    push_job(MODE_INT4_VSQ, 16'd8, 4'd5);
    wait_start(10);
    push_job(MODE_INT4, 16'd2, 4'd6);
    k = 1;
    while (k < 40 && !o_cmp_valid) begin
      tick();
      k++;
    end
    check("timeout_latency", k, 11);
    for (int i = 0; i < 15; i++) tick();
    check("halt_busy", o_busy, 1);
    check("halt_no_start", o_mm_start, 0);
    i_timeout = '0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_halt_idle", o_busy, 0);
    for (int i = 0; i < 5; i++) tick();
    check("halt_queue_flushed", o_busy, 0);

    // Abort while running with two jobs queued.
    expect_job(MODE_INT4, 4'd7, CMP_OK, 1'b0);
    push_job(MODE_INT4, 16'd4, 4'd7);
    wait_start(10);
    tick();
    push_job(MODE_INT8, 16'd1, 4'd8);
    push_job(MODE_INT4_VSQ, 16'd1, 4'd9);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("drain_busy", o_busy, 1);
    check("drain_cmp_valid", o_cmp_valid, 0);
    i_mm_tile_done = 1'b1;
    tick();
    i_mm_tile_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("drain_waits_mtrx", o_busy, 1);
    i_mm_mtrx_done = 1'b1;
    tick();
    i_mm_mtrx_done = 1'b0;
    check("drain_exit_idle", o_busy, 0);
    for (int i = 0; i < 5; i++) tick();
    check("drain_queue_flushed", o_busy, 0);

    // Back-pressured report stays stable and blocks the next issue.
    i_cmp_ready = 1'b0;
    expect_job(MODE_INT4_VSQ, 4'd10, CMP_OK, 1'b1);
    push_job(MODE_INT4_VSQ, 16'd2, 4'd10);
    wait_start(10);
    tick();
    drive_tiles(2, 1'b1);
    push_job(MODE_INT4, 16'd1, 4'd12);
    check("report_valid", o_cmp_valid, 1);
    tag0 = o_cmp_tag;
    st0  = o_cmp_status;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!o_cmp_valid || o_cmp_tag !== tag0 || o_cmp_status !== st0 || o_mm_start) errs++;
    end
    check("report_hold_stable", errs, 0);
    expect_job(MODE_INT4, 4'd12, CMP_OK, 1'b0);
    i_cmp_ready = 1'b1;
    wait_start(20);
    tick();
    i_mm_tile_done = 1'b1;
    tick();
    i_mm_tile_done = 1'b0;
    check("run_busy_before_rst", o_busy, 1);

    // Asynchronous reset in the middle of a cycle.
    #2 i_rst = 1'b1;
    exp_mode = '0;
    #1;
    check("arst_start", o_mm_start, 0);
    check("arst_mode", o_mm_mode, 0);
    check("arst_cmp_valid", o_cmp_valid, 0);
    check("arst_cmp_tag", o_cmp_tag, 0);
    check("arst_cmp_status", o_cmp_status, 0);
    check("arst_busy", o_busy, 0);
    check("arst_job_ready", o_job_ready, 1);
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_idle", o_busy, 0);

    check("exp_start_drained", exp_start.size(), 0);
    check("exp_cmp_drained", exp_cmp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
